// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } pc_state_t;

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_REDIRECT,
    PEND_TRAP
  } pend_kind_t;

  // Clears the sub-instruction offset bits; instr_bytes must be a power of two.
  function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
    return ~(64'(instr_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push into a full stack overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;
  logic [PW-1:0]   wr_idx;
  logic            swap;

  assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - PW'(1);
  assign empty   = (cnt_q == '0);
  assign top     = mem[ptr_q];

  // Simultaneous push and pop on a non-empty stack replaces the top in place.
  assign swap    = push && pop && !empty;
  assign wr_idx  = swap ? ptr_q : ptr_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (swap) begin
      ptr_q <= ptr_q;
    end else if (push) begin
      ptr_q <= ptr_inc;
      if (cnt_q != CW'(DEPTH)) cnt_q <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_dec;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with boot/run/halt sequencing, stall-safe pending redirect and trap.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
`ifdef PC_RAS_EN
  input  logic            ras_push,
  input  logic            ras_pop,
`endif
  output logic [XLEN-1:0] instru_addr,
  output logic            fetch_valid,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(INSTR_BYTES));

  pc_state_t       state_q, state_d;
  pend_kind_t      pend_q, pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            mis_q, mis_d;
  logic            take;
  logic [XLEN-1:0] tgt;
  logic            pop_hit;
  logic [XLEN-1:0] pop_tgt;

`ifdef PC_RAS_EN
  logic            run_go;
  logic            ras_empty;
  logic [XLEN-1:0] ras_top;

  assign run_go = (state_q == ST_RUN) && !stall;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .XLEN  (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (run_go && ras_push),
    .pop       (run_go && ras_pop),
    .push_data (addr_q + XLEN'(INSTR_BYTES)),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  assign pop_hit = ras_pop && !ras_empty;
  assign pop_tgt = ras_top;
`else
  assign pop_hit = 1'b0;
  assign pop_tgt = '0;
`endif

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    addr_d     = addr_q;
    mis_d      = 1'b0;
    take       = 1'b0;
    tgt        = '0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (stall) begin
          // A held trap can only be displaced by another trap.
          if (trap_valid) begin
            pend_d     = PEND_TRAP;
            pend_tgt_d = trap_vector;
          end else if (redirect_valid && pend_q != PEND_TRAP) begin
            pend_d     = PEND_REDIRECT;
            pend_tgt_d = redirect_target;
          end
        end else begin
          pend_d = PEND_NONE;
          if (trap_valid) begin
            take = 1'b1;
            tgt  = trap_vector;
          end else if (pend_q == PEND_TRAP) begin
            take = 1'b1;
            tgt  = pend_tgt_q;
          end else if (redirect_valid) begin
            take = 1'b1;
            tgt  = redirect_target;
          end else if (pend_q == PEND_REDIRECT) begin
            take = 1'b1;
            tgt  = pend_tgt_q;
          end else if (pop_hit) begin
            take = 1'b1;
            tgt  = pop_tgt;
          end else if (halt) begin
            state_d = ST_HALT;
          end else begin
            addr_d = addr_q + XLEN'(INSTR_BYTES);
          end
        end
      end
      ST_HALT: begin
        if (trap_valid) begin
          take    = 1'b1;
          tgt     = trap_vector;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    if (take) begin
      addr_d = tgt & ALIGN_MASK;
      mis_d  = |(tgt & ~ALIGN_MASK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pend_q     <= PEND_NONE;
      pend_tgt_q <= '0;
      addr_q     <= RESET_VECTOR;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      addr_q     <= addr_d;
      mis_q      <= mis_d;
    end
  end

  assign instru_addr = addr_q;
  assign fetch_valid = (state_q == ST_RUN);
  assign misaligned  = mis_q;

endmodule
